// File: rtl/health_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : health_pkg
//  Description : Shared types, widths, heart-count constants and saturating
//                arithmetic helpers for the health controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package health_pkg;

    localparam int HEALTH_W = 2;

    localparam logic [HEALTH_W-1:0] NO_HEARTS    = 2'b00;
    localparam logic [HEALTH_W-1:0] ONE_HEART    = 2'b01;
    localparam logic [HEALTH_W-1:0] TWO_HEARTS   = 2'b10;
    localparam logic [HEALTH_W-1:0] THREE_HEARTS = 2'b11;
    localparam logic [HEALTH_W-1:0] MAX_HEALTH   = THREE_HEARTS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIVE  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    function automatic logic [HEALTH_W-1:0] sat_inc(input logic [HEALTH_W-1:0] h);
        return (h == MAX_HEALTH) ? h : h + ONE_HEART;
    endfunction

    function automatic logic [HEALTH_W-1:0] sat_dec(input logic [HEALTH_W-1:0] h);
        return (h == NO_HEARTS) ? h : h - ONE_HEART;
    endfunction

endpackage
`default_nettype wire

// File: rtl/health_timer.sv
`default_nettype none
// ============================================================================
//  Module      : health_timer
//  Description : Loadable down-counter with enable and zero flag; holds at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module health_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/health_controller.sv
`default_nettype none
// ============================================================================
//  Module      : health_controller
//  Description : Owns the player's heart count: hit/heal, post-hit
//                invulnerability window, game over. Define HEALTH_BLINK_EN to
//                blink the display code during the invulnerability window.
//  Revision    : 1.0 - initial release
// ============================================================================
module health_controller
    import health_pkg::*;
#(
    parameter int INVULN_CYCLES = 4,
    parameter int START_HEALTH  = 3,
    parameter int BLINK_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hit,
    input  logic                heal,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] health_disp,
    output logic                invulnerable,
    output logic                game_over,
    output logic                hit_taken
);

    localparam int TIMER_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [TIMER_W-1:0]  C_INV_RELOAD = TIMER_W'(INVULN_CYCLES - 1);
    localparam logic [HEALTH_W-1:0] C_START      = HEALTH_W'(START_HEALTH);

    if (INVULN_CYCLES < 1 || START_HEALTH < 1 || START_HEALTH > 3 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("health_controller: parameter out of range");
    end

    state_t                r_state, w_state_next;
    logic [HEALTH_W-1:0]   r_health, w_health_next;
    logic                  r_hit_taken, w_hit_taken_next;
    logic                  w_hit_applied;
    logic                  w_inv_load, w_inv_en, w_inv_zero;
    logic [TIMER_W-1:0]    w_inv_value;

    assign w_hit_applied = !start && (r_state == ALIVE) && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ALIVE;
        end else begin
            case (r_state)
                ALIVE:   if (hit) w_state_next = (sat_dec(r_health) == NO_HEARTS) ? DEAD : INVULN;
                INVULN:  if (w_inv_zero) w_state_next = ALIVE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Next values for the registered outputs and timer controls.
    always_comb begin
        w_health_next    = r_health;
        w_hit_taken_next = 1'b0;
        w_inv_load       = 1'b0;
        w_inv_en         = 1'b0;
        w_inv_value      = '0;
        if (start) begin
            w_health_next = C_START;
            w_inv_load    = 1'b1;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (hit) begin
                        w_health_next    = sat_dec(r_health);
                        w_hit_taken_next = 1'b1;
                        w_inv_load       = 1'b1;
                        w_inv_value      = C_INV_RELOAD;
                    end else if (heal) begin
                        w_health_next = sat_inc(r_health);
                    end
                end
                INVULN: begin
                    w_inv_en = 1'b1;
                    if (heal) w_health_next = sat_inc(r_health);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_health    <= NO_HEARTS;
            r_hit_taken <= 1'b0;
        end else begin
            r_health    <= w_health_next;
            r_hit_taken <= w_hit_taken_next;
        end
    end

    health_timer #(.WIDTH(TIMER_W)) u_inv_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_inv_load),
        .en         (w_inv_en),
        .load_value (w_inv_value),
        .zero       (w_inv_zero)
    );

    assign health       = r_health;
    assign invulnerable = (r_state == INVULN);
    assign game_over    = (r_state == DEAD);
    assign hit_taken    = r_hit_taken;

`ifdef HEALTH_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] C_BLINK_RELOAD = BLINK_W'(BLINK_CYCLES - 1);

    logic w_blink_load, w_blink_zero, r_blink_off;

    // Phase restarts visible on every applied hit; toggles each time the period expires.
    assign w_blink_load = start || w_hit_applied || ((r_state == INVULN) && w_blink_zero);

    health_timer #(.WIDTH(BLINK_W)) u_blink_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_blink_load),
        .en         (r_state == INVULN),
        .load_value (C_BLINK_RELOAD),
        .zero       (w_blink_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_off <= 1'b0;
        end else if (start || w_hit_applied) begin
            r_blink_off <= 1'b0;
        end else if ((r_state == INVULN) && w_blink_zero) begin
            r_blink_off <= ~r_blink_off;
        end
    end

    assign health_disp = ((r_state == INVULN) && r_blink_off) ? NO_HEARTS : r_health;
`else
    assign health_disp = r_health;
`endif

endmodule
`default_nettype wire

// File: tb/tb_health_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_health_controller
//  Description : Directed and random stimulus against a behavioural model of
//                the health controller (honours HEALTH_BLINK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_health_controller;

    localparam int INV   = 4;
    localparam int START = 3;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, hit = 1'b0, heal = 1'b0;
    logic [1:0] health, health_disp;
    logic       invulnerable, game_over, hit_taken;

    health_controller #(
        .INVULN_CYCLES (INV),
        .START_HEALTH  (START),
        .BLINK_CYCLES  (BLINK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hit          (hit),
        .heal         (heal),
        .health       (health),
        .health_disp  (health_disp),
        .invulnerable (invulnerable),
        .game_over    (game_over),
        .hit_taken    (hit_taken)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode 0=idle 1=alive 2=window 3=dead; m_left = window cycles still to show.
    int m_health, m_mode, m_left, m_hit;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_disp();
`ifdef HEALTH_BLINK_EN
        if (m_mode == 2 && (((INV - m_left) / BLINK) % 2) == 1) return 0;
`endif
        return m_health;
    endfunction

    task automatic model_reset();
        m_health = 0; m_mode = 0; m_left = 0; m_hit = 0;
    endtask

    task automatic model_edge(input logic s, input logic h, input logic he);
        m_hit = 0;
        if (s) begin
            m_health = START; m_mode = 1; m_left = 0;
        end else if (m_mode == 1) begin
            if (h) begin
                m_health = (m_health > 0) ? m_health - 1 : 0;
                m_hit = 1;
                if (m_health == 0) m_mode = 3;
                else begin m_mode = 2; m_left = INV; end
            end else if (he) begin
                m_health = (m_health < 3) ? m_health + 1 : 3;
            end
        end else if (m_mode == 2) begin
            if (he) m_health = (m_health < 3) ? m_health + 1 : 3;
            m_left--;
            if (m_left == 0) m_mode = 1;
        end
    endtask

    task automatic compare_all();
        check("health", 8'(health), 8'(m_health));
        check("disp", 8'(health_disp), 8'(model_disp()));
        check("invuln", 8'(invulnerable), 8'(m_mode == 2));
        check("game_over", 8'(game_over), 8'(m_mode == 3));
        check("hit_taken", 8'(hit_taken), 8'(m_hit));
    endtask

    task automatic cycle(input logic s, input logic h, input logic he);
        @(negedge clk);
        start = s; hit = h; heal = he;
        @(posedge clk);
        model_edge(s, h, he);
        #1 compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; hit = 1'b0; heal = 1'b0;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_disp[4];

    initial begin
        model_reset();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Idle ignores events
        cycle(0, 1, 0); cycle(0, 0, 1); cycle(0, 1, 1);
        check("idle_health", 8'(health), 8'd0);

        // First hit and window behaviour
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        check("hit_3to2", 8'(health), 8'd2);
        check("hit_pulse", 8'(hit_taken), 8'd1);
        cycle(0, 1, 0);
        check("win_hit_ign", 8'(health), 8'd2);
        check("pulse_width", 8'(hit_taken), 8'd0);
        repeat (3) cycle(0, 0, 0);
        check("win_end", 8'(invulnerable), 8'd0);

        // Heal saturation
        cycle(1, 0, 0); cycle(0, 0, 1);
        check("heal_sat", 8'(health), 8'd3);
        cycle(0, 1, 0); repeat (4) cycle(0, 0, 0);
        cycle(0, 0, 1); cycle(0, 0, 1);
        check("heal_2to3", 8'(health), 8'd3);

        // Three hits to death, hit right after window ends
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0);
            if (i < 2) repeat (4) cycle(0, 0, 0);
        end
        check("dead_hp", 8'(health), 8'd0);
        check("dead_flag", 8'(game_over), 8'd1);
        cycle(0, 1, 1);
        cycle(1, 0, 0);
        check("restart", 8'(health), 8'd3);

        // Priorities and reset mid-window
        cycle(1, 1, 0);
        check("start_prio", 8'(hit_taken), 8'd0);
        cycle(0, 1, 1);
        check("hit_heal", 8'(health), 8'd2);
        cycle(0, 0, 0);
        apply_reset();

        // Blink pattern from health 3
`ifdef HEALTH_BLINK_EN
        exp_disp = '{2, 2, 0, 0};
`else
        exp_disp = '{2, 2, 2, 2};
`endif
        cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, (i == 0), 0);
            check("blink", 8'(health_disp), 8'(exp_disp[i]));
        end
        cycle(0, 0, 0);
        check("blink_after", 8'(health_disp), 8'd2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            else cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                       $urandom_range(0, 99) < 25);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
